// File: rtl/if_id_skid_reg_if.sv
// Valid/ready beat carrying LANES fetch slots (PC, instruction, lane mask).
interface if_id_skid_reg_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned LANES  = 1
);
   logic                      valid;
   logic                      ready;
   logic [LANES*PC_W-1:0]     pc;
   logic [LANES*INST_W-1:0]   inst;
   logic [LANES-1:0]          mask;

   // Producer of a beat drives payload and valid, consumer drives ready.
   modport master (output valid, output pc, output inst, output mask, input ready);
   modport slave  (input valid, input pc, input inst, input mask, output ready);
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline boundary: 2-entry skid buffer with flush-to-bubble and a
// saturating starvation counter. in_ready depends only on registered state.
module if_id_skid_reg #(
   parameter int unsigned        PC_W     = 32,
   parameter int unsigned        INST_W   = 32,
   parameter int unsigned        LANES    = 1,
   parameter logic [INST_W-1:0]  NOP_INST = '0,
   parameter int unsigned        CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   if_id_skid_reg_if.slave      in_if,
   if_id_skid_reg_if.master     out_if,
   output logic [1:0]           occupancy_o,
   output logic [CNT_W-1:0]     bubble_cnt_o
);

   localparam int unsigned PCV_W   = LANES * PC_W;
   localparam int unsigned INSTV_W = LANES * INST_W;
   localparam logic [INSTV_W-1:0] NOP_VEC = {LANES{NOP_INST}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   logic                 ready_q, ready_d;
   logic [PCV_W-1:0]     main_pc_q, main_pc_d;
   logic [INSTV_W-1:0]   main_inst_q, main_inst_d;
   logic [LANES-1:0]     main_mask_q, main_mask_d;
   logic [PCV_W-1:0]     skid_pc_q, skid_pc_d;
   logic [INSTV_W-1:0]   skid_inst_q, skid_inst_d;
   logic [LANES-1:0]     skid_mask_q, skid_mask_d;
   logic [CNT_W-1:0]     bubble_q, bubble_d;

   logic                 in_fire;
   logic                 out_fire;

   assign in_fire  = in_if.valid & ready_q;
   assign out_fire = valid_q & out_if.ready;

   // Next-state: flush wins, otherwise walk EMPTY/ONE/FULL on the two fires.
   always_comb begin
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      main_mask_d = main_mask_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
      skid_mask_d = skid_mask_q;
      bubble_d    = bubble_q;

      if (flush_i) begin
         state_d     = EMPTY;
         main_inst_d = NOP_VEC;
         main_mask_d = '0;
         skid_inst_d = NOP_VEC;
         skid_mask_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d     = ONE;
                  main_pc_d   = in_if.pc;
                  main_inst_d = in_if.inst;
                  main_mask_d = in_if.mask;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_pc_d   = in_if.pc;
                  main_inst_d = in_if.inst;
                  main_mask_d = in_if.mask;
               end else if (in_fire) begin
                  state_d     = FULL;
                  skid_pc_d   = in_if.pc;
                  skid_inst_d = in_if.inst;
                  skid_mask_d = in_if.mask;
               end else if (out_fire) begin
                  // Drained: present a bubble, keep the last PC for debug.
                  state_d     = EMPTY;
                  main_inst_d = NOP_VEC;
                  main_mask_d = '0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d     = ONE;
                  main_pc_d   = skid_pc_q;
                  main_inst_d = skid_inst_q;
                  main_mask_d = skid_mask_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      valid_d = (state_d != EMPTY);
      ready_d = (state_d != FULL);

      // Starved decode cycles; flush has no effect on the count.
      if (out_if.ready && !valid_q && (bubble_q != '1)) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         valid_q     <= 1'b0;
         ready_q     <= 1'b1;
         main_pc_q   <= '0;
         main_inst_q <= NOP_VEC;
         main_mask_q <= '0;
         skid_pc_q   <= '0;
         skid_inst_q <= NOP_VEC;
         skid_mask_q <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         ready_q     <= ready_d;
         main_pc_q   <= main_pc_d;
         main_inst_q <= main_inst_d;
         main_mask_q <= main_mask_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
         skid_mask_q <= skid_mask_d;
         bubble_q    <= bubble_d;
      end
   end

   assign in_if.ready  = ready_q;
   assign out_if.valid = valid_q;
   assign out_if.pc    = main_pc_q;
   assign out_if.inst  = main_inst_q;
   assign out_if.mask  = main_mask_q;
   assign occupancy_o  = 2'(state_q);
   assign bubble_cnt_o = bubble_q;

endmodule
